// File: rtl/apb_uart_rx_fifo_regs.sv
// APB register block for the UART receiver: RX FIFO with size masking, sticky
// error flags, interrupt enables/threshold and receiver configuration outputs.
module apb_uart_rx_fifo_regs #(
   parameter int          FIFO_DEPTH       = 8,
   parameter logic [13:0] RESET_BIT_PERIOD = 14'd10,
   parameter logic [3:0]  RESET_DATA_SIZE  = 4'd8
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [3:0]  paddr,
   input  logic [7:0]  pwdata,
   output logic [7:0]  prdata,
   output logic        pslverr,
   input  logic [7:0]  rx_data,
   input  logic        data_ready,
   input  logic        overrun_error,
   input  logic        framing_error,
   output logic        data_read,
   output logic [3:0]  data_size,
   output logic [13:0] bit_period,
   output logic        irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
   localparam logic [7:0]  DEPTH_8 = 8'(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   irq_thr;
   logic [2:0]    irq_en;
   logic          err_ovr, err_frm;
   logic          full, empty;
   logic          acc_wr, acc_rd, push, pop;
   logic [7:0]    size_mask;

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   // APB decode: read data and error are purely combinational from the
   // address phase so they are valid in both setup and access phases.
   always_comb begin
      prdata  = 8'h00;
      pslverr = 1'b0;
      if (psel) begin
         if (paddr > 4'd8) begin
            pslverr = 1'b1;
         end else if (pwrite) begin
            case (paddr)
               4'd0, 4'd1, 4'd5, 4'd6: pslverr = 1'b1;
               4'd4: pslverr = !((pwdata == 8'd5) || (pwdata == 8'd7) || (pwdata == 8'd8));
               4'd8: pslverr = (pwdata == 8'd0) || (pwdata > DEPTH_8);
               default: pslverr = 1'b0;
            endcase
         end else begin
            case (paddr)
               4'd0: prdata = {6'b0, full, !empty};
               4'd1: prdata = {6'b0, err_ovr, err_frm};
               4'd2: prdata = bit_period[7:0];
               4'd3: prdata = {2'b0, bit_period[13:8]};
               4'd4: prdata = {4'b0, data_size};
               4'd5: prdata = 8'(count);
               4'd6: prdata = empty ? 8'h00 : mem[rd_ptr];
               4'd7: prdata = {5'b0, irq_en};
               4'd8: prdata = 8'(irq_thr);
               default: prdata = 8'h00;
            endcase
         end
      end
   end

   assign acc_wr = psel && penable && pwrite && !pslverr;
   assign acc_rd = psel && penable && !pwrite && !pslverr;
   assign pop    = acc_rd && (paddr == 4'd6) && !empty;

   // UART handshake: data_ready is a level meaning "byte valid on rx_data";
   // data_read is a one-cycle acknowledge and the byte is captured on the edge
   // that ends that cycle. data_read is never raised two cycles in a row, so
   // the UART has a cycle to drop data_ready before another pop can occur.
   assign push = data_read;

   always_comb begin
      case (data_size)
         4'd5:    size_mask = 8'h1F;
         4'd7:    size_mask = 8'h7F;
         default: size_mask = 8'hFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (n_rst && push)
         mem[wr_ptr] <= rx_data & size_mask;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         err_ovr    <= 1'b0;
         err_frm    <= 1'b0;
         irq_en     <= 3'b0;
         irq_thr    <= {{AW{1'b0}}, 1'b1};
         bit_period <= RESET_BIT_PERIOD;
         data_size  <= RESET_DATA_SIZE;
         data_read  <= 1'b0;
         irq        <= 1'b0;
      end else begin
         data_read <= data_ready && !full && !data_read;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A clearing read still lets an error asserted in the same cycle stick.
         if (acc_rd && (paddr == 4'd1)) begin
            err_ovr <= overrun_error;
            err_frm <= framing_error;
         end else begin
            err_ovr <= err_ovr | overrun_error;
            err_frm <= err_frm | framing_error;
         end
         if (acc_wr) begin
            case (paddr)
               4'd2:    bit_period[7:0]  <= pwdata;
               4'd3:    bit_period[13:8] <= pwdata[5:0];
               4'd4:    data_size        <= pwdata[3:0];
               4'd7:    irq_en           <= pwdata[2:0];
               4'd8:    irq_thr          <= pwdata[AW:0];
               default: ;
            endcase
         end
         irq <= (irq_en[0] && !empty) ||
                (irq_en[1] && (err_ovr || err_frm)) ||
                (irq_en[2] && (count >= irq_thr));
      end
   end
endmodule

// File: doc/apb_uart_rx_fifo_regs.md
# apb_uart_rx_fifo_regs

APB-slave register block for the UART receiver, successor to the single-byte `apb_slave`. It drains received bytes into a parametrised RX FIFO and masks each byte to the configured data size. It also provides sticky error flags, an interrupt with enable and threshold controls, and legality checks on configuration writes. It sits between the APB bus and `rcv_block`, and drives `bit_period` and `data_size` to the receiver.

## Interface
- FIFO_DEPTH, 8, RX FIFO entries; power of 2, 2..16.
- RESET_BIT_PERIOD, 14'd10, bit_period value after reset.
- RESET_DATA_SIZE, 4'd8, data_size value after reset.
- Clocking: one clock; reset is synchronous and active-low.
- clk  in  1  system clock
- n_rst  in  1  synchronous active-low reset
- psel, penable, pwrite  in  1 each  APB controls
- paddr  in  4  register address
- pwdata  in  8  write data
- prdata  out  8  read data
- pslverr  out  1  APB error
- rx_data  in  8  received byte from the UART
- data_ready  in  1  UART byte available (level)
- overrun_error, framing_error  in  1 each  UART error levels
- data_read  out  1  one-cycle pop pulse to the UART
- data_size  out  4  configured bits per frame
- bit_period  out  14  configured clocks per bit
- irq  out  1  registered interrupt

## Operation
- Register map (R = read-only, RW = read/write):
  - 0 STATUS (R): {6'b0, full, !empty}.
  - 1 ERROR (R): {6'b0, overrun, framing}; both bits sticky; a read clears them.
  - 2 BIT_CR0 (RW): bit_period[7:0].
  - 3 BIT_CR1 (RW): {2'b0, bit_period[13:8]}; writes ignore pwdata[7:6].
  - 4 DATA_CR (RW): {4'b0, data_size}.
  - 5 COUNT (R): FIFO occupancy, 0..FIFO_DEPTH.
  - 6 RX_DATA (R): head byte; a read pops the FIFO.
  - 7 IRQ_EN (RW): bit0 not-empty, bit1 error, bit2 threshold; bits[7:3] read 0.
  - 8 IRQ_THR (RW): threshold, 1..FIFO_DEPTH.
- pslverr=1 on any of these accesses; the register state is left unchanged:
  - any address 9..15;
  - a write to 0, 1, 5 or 6;
  - a DATA_CR write with a value not in {5,7,8};
  - an IRQ_THR write of 0 or of a value greater than FIFO_DEPTH.
- UART drain: data_read=1 for one cycle when data_ready=1, the FIFO is not full, and data_read was 0 in the previous cycle. This guard prevents a double pop while the UART drops data_ready.
- The pushed byte is rx_data masked by size: 5 -> 0x1F, 7 -> 0x7F, 8 -> 0xFF. The mask uses the data_size in effect at push time.
- FIFO full: no data_read is issued. The UART keeps its byte, and its own overrun_error reports any loss.
- Sticky error bits are set on any cycle where the matching input is 1. If a set and a clearing read of ERROR occur in the same cycle, the bit stays 1.
- RX_DATA read with the FIFO empty: returns 0x00, no pop, pslverr=0.
- Simultaneous push and pop: occupancy is unchanged and the data order is preserved. Pop with 1 entry plus push: the new byte becomes the head.
- irq is registered and asserts when any of these holds:
  - IRQ_EN[0] and !empty;
  - IRQ_EN[1] and (overrun | framing);
  - IRQ_EN[2] and COUNT >= IRQ_THR.
- Read/write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Occupancy is a separate counter, log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset (n_rst=0 at a rising edge) clears the FIFO, the error bits, IRQ_EN and the pointers, and sets IRQ_THR=1. Values after that edge:
  - prdata=0, pslverr=0, data_read=0, irq=0;
  - bit_period=RESET_BIT_PERIOD, data_size=RESET_DATA_SIZE.
- A reset mid-transfer aborts the transfer with no register update.
- APB runs zero-wait-state:
  - setup phase: psel=1, penable=0;
  - access phase: psel=1, penable=1.
- prdata and pslverr are combinational from paddr/pwrite while psel=1, and 0 when psel=0. They are valid throughout both phases.
- Write side effects, read pops and ERROR clears take effect at the rising edge that ends the access phase. There is exactly one effect per transfer.
- data_size and bit_period change at that same edge.
- Push latency: data_ready rising -> data_read on the next edge -> entry visible in COUNT/STATUS one cycle after data_read.
- irq follows its condition with 1-cycle latency.

## Test plan
- Reset check:
  - Stimulus: hold rx_data=0xFF and all UART inputs =1, then reset.
  - Required: bit_period=10, data_size=8, data_read=0, irq=0, COUNT=0.
- Configuration write/readback:
  - Stimulus: write BIT_CR0=0xE8 and BIT_CR1=0xC3.
  - Required: bit_period=1000, and CR1 reads back 0x03.
  - Stimulus: write DATA_CR=6.
  - Required: pslverr=1 and data_size stays 8.
- FIFO fill:
  - Stimulus: with data_size=7, push 0xFF, 0x81, 0x02 via the data_ready handshake.
  - Required: three single-cycle data_read pulses, then RX_DATA reads 0x7F, 0x01, 0x02, then 0x00 (empty) with pslverr=0.
- Full and wrap:
  - Stimulus: push 8 bytes, then hold data_ready=1.
  - Required: no further data_read and STATUS=0x03.
  - Stimulus: pop one byte.
  - Required: exactly one new data_read follows, and all 9 bytes read back in order across the pointer wrap.
- Errors and irq:
  - Stimulus: pulse framing_error; set IRQ_EN=0x02.
  - Required: irq=1 one cycle later; ERROR read returns 0x01, then 0x00; irq then drops.
  - Stimulus: IRQ_EN=0x04, IRQ_THR=3, push 3 bytes.
  - Required: irq=1.
- Illegal access:
  - Stimulus: write to address 5, read address 12, write IRQ_THR=9.
  - Required: pslverr=1 each time and no state change.
